// File: rtl/alt_vipvfr131_common_pkg.sv
// Shared constants for alt_vipvfr131_common blocks: trigger-responder state encodings.
package alt_vipvfr131_common_pkg;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_REQ  = 2'd1;
  localparam logic [1:0] STATE_BUSY = 2'd2;
  localparam logic [1:0] STATE_ACK  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = STATE_IDLE,
    ST_REQ  = STATE_REQ,
    ST_BUSY = STATE_BUSY,
    ST_ACK  = STATE_ACK
  } trig_state_e;

endpackage

// File: rtl/alt_vipvfr131_common_sat_updown_counter.sv
// Saturating up/down counter; simultaneous inc and dec cancel out.
module alt_vipvfr131_common_sat_updown_counter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  logic [WIDTH-1:0] r_count;

  assign count  = r_count;
  assign at_max = (r_count == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && !dec && !at_max) begin
      r_count <= r_count + WIDTH'(1);
    end else if (dec && !inc && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/alt_vipvfr131_common_trigger_responder.sv
// Queues trigger pulses, hands them one at a time to a downstream engine and
// acknowledges each completion (or watchdog expiry) back to the trigger source.
module alt_vipvfr131_common_trigger_responder
  import alt_vipvfr131_common_pkg::*;
#(
  parameter int unsigned PENDING_WIDTH  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned TIMEOUT_WIDTH  = 16
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     trigger_in,
  output logic                     go,
  input  logic                     go_accept,
  input  logic                     done_in,
  output logic                     ack_out,
  output logic                     busy,
  output logic [PENDING_WIDTH-1:0] pending_count,
  output logic                     overflow,
  input  logic                     clear_overflow,
  output logic                     timeout
);

  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  // Expiry fires on the edge where the BUSY cycle count reaches TIMEOUT_CYCLES.
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST =
    WD_EN ? TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  trig_state_e              r_state;
  trig_state_e              w_next;
  logic [TIMEOUT_WIDTH-1:0] r_wd;
  logic [PENDING_WIDTH-1:0] w_count;
  logic                     w_at_max;
  logic                     w_dec;
  logic                     w_drop;
  logic                     w_expire;
  logic                     w_timeout;
  logic                     r_go;
  logic                     r_busy;
  logic                     r_ack;
  logic                     r_overflow;
  logic                     r_timeout;

  assign w_dec    = (r_state == ST_REQ) && go_accept;
  assign w_drop   = trigger_in && w_at_max && !w_dec;
  assign w_expire = WD_EN && (r_wd == WD_LAST);

  alt_vipvfr131_common_sat_updown_counter #(
    .WIDTH (PENDING_WIDTH)
  ) u_pending (
    .clk    (clock),
    .rst    (rst),
    .inc    (trigger_in),
    .dec    (w_dec),
    .count  (w_count),
    .at_max (w_at_max)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: if (w_count != '0) w_next = ST_REQ;
      ST_REQ:  if (go_accept) w_next = ST_BUSY;
      ST_BUSY: begin
        if (done_in) begin
          w_next = ST_ACK;
        end else if (w_expire) begin
          w_next    = ST_ACK;
          w_timeout = 1'b1;
        end
      end
      ST_ACK:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Watchdog: cleared on BUSY entry, counts BUSY cycles, saturates.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_wd <= '0;
    end else if (w_dec) begin
      r_wd <= '0;
    end else if ((r_state == ST_BUSY) && (r_wd != '1)) begin
      r_wd <= r_wd + TIMEOUT_WIDTH'(1);
    end
  end

  // Outputs registered from the next state so they line up with r_state.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_go       <= 1'b0;
      r_busy     <= 1'b0;
      r_ack      <= 1'b0;
      r_timeout  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_go      <= (w_next == ST_REQ);
      r_busy    <= (w_next != ST_IDLE);
      r_ack     <= (w_next == ST_ACK);
      r_timeout <= w_timeout;
      if (w_drop)              r_overflow <= 1'b1;
      else if (clear_overflow) r_overflow <= 1'b0;
    end
  end

  assign go            = r_go;
  assign busy          = r_busy;
  assign ack_out       = r_ack;
  assign timeout       = r_timeout;
  assign overflow      = r_overflow;
  assign pending_count = w_count;

endmodule

// File: tb/tb_alt_vipvfr131_common_trigger_responder.sv
// Scoreboard bench: instance a (no watchdog) and instance b (TIMEOUT_CYCLES=8).
module tb_alt_vipvfr131_common_trigger_responder;

  typedef struct {
    int cyc;
    int to;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig_a = 1'b0, acc_a = 1'b0, done_a = 1'b0, clr_a = 1'b0;
  logic       trig_b = 1'b0, acc_b = 1'b0, done_b = 1'b0, clr_b = 1'b0;
  logic       go_a, ack_a, busy_a, ovf_a, to_a;
  logic       go_b, ack_b, busy_b, ovf_b, to_b;
  logic [1:0] pend_a, pend_b;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  alt_vipvfr131_common_trigger_responder #(
    .PENDING_WIDTH(2), .TIMEOUT_CYCLES(0), .TIMEOUT_WIDTH(16)
  ) dut_a (
    .clock(clk), .rst(rst), .trigger_in(trig_a), .go(go_a), .go_accept(acc_a),
    .done_in(done_a), .ack_out(ack_a), .busy(busy_a), .pending_count(pend_a),
    .overflow(ovf_a), .clear_overflow(clr_a), .timeout(to_a)
  );

  alt_vipvfr131_common_trigger_responder #(
    .PENDING_WIDTH(2), .TIMEOUT_CYCLES(8), .TIMEOUT_WIDTH(16)
  ) dut_b (
    .clock(clk), .rst(rst), .trigger_in(trig_b), .go(go_b), .go_accept(acc_b),
    .done_in(done_b), .ack_out(ack_b), .busy(busy_b), .pending_count(pend_b),
    .overflow(ovf_b), .clear_overflow(clr_b), .timeout(to_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_go(input bit sel);
    int n = 0;
    while (!(sel ? go_b : go_a) && n < 50) begin
      tick();
      n++;
    end
    check(sel ? "wait_go_b" : "wait_go_a", int'(sel ? go_b : go_a), 1);
  endtask

  // Engine model for instance a: accept after acc_dly, complete done_dly cycles later.
  task automatic serve_a(input int acc_dly, input int done_dly);
    exp_t e;
    wait_go(1'b0);
    repeat (acc_dly) tick();
    acc_a = 1'b1;
    tick();
    acc_a = 1'b0;
    repeat (done_dly) tick();
    e.cyc = cyc + 1;
    e.to  = 0;
    q_a.push_back(e);
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    tick();
  endtask

  task automatic check_idle_a(input string name);
    check({name, "_go"}, int'(go_a), 0);
    check({name, "_busy"}, int'(busy_a), 0);
    check({name, "_pend"}, int'(pend_a), 0);
  endtask

  // Monitors: every ack/timeout pulse must match the next expected entry.
  always @(negedge clk) begin
    if (ack_a || to_a) begin
      if (q_a.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL ack_a_unexpected: ack=%0d timeout=%0d at cycle %0d, required no pulse",
                 ack_a, to_a, cyc);
      end else begin
        e_a = q_a.pop_front();
        check("ack_a_cycle", cyc, e_a.cyc);
        check("ack_a_present", int'(ack_a), 1);
        check("ack_a_timeout", int'(to_a), e_a.to);
      end
    end
  end

  always @(negedge clk) begin
    if (ack_b || to_b) begin
      if (q_b.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL ack_b_unexpected: ack=%0d timeout=%0d at cycle %0d, required no pulse",
                 ack_b, to_b, cyc);
      end else begin
        e_b = q_b.pop_front();
        check("ack_b_cycle", cyc, e_b.cyc);
        check("ack_b_present", int'(ack_b), 1);
        check("ack_b_timeout", int'(to_b), e_b.to);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation still running at time %0t, required completion", $time);
    $fatal(1, "time limit");
  end

  initial begin
    exp_t e;
    // Reset state
    repeat (3) tick();
    check("rst_a_outputs", int'({go_a, ack_a, busy_a, ovf_a, to_a, pend_a}), 0);
    check("rst_b_outputs", int'({go_b, ack_b, busy_b, ovf_b, to_b, pend_b}), 0);
    rst = 1'b0;
    tick();

    // Single trigger: go one edge after the pending count rises
    trig_a = 1'b1;
    tick();
    trig_a = 1'b0;
    check("single_pend1", int'(pend_a), 1);
    check("single_go_not_yet", int'(go_a), 0);
    tick();
    check("single_go_latency", int'(go_a), 1);
    tick();
    tick();
    check("single_go_held", int'(go_a), 1);
    acc_a = 1'b1;
    tick();
    acc_a = 1'b0;
    check("single_go_dropped", int'(go_a), 0);
    check("single_busy", int'(busy_a), 1);
    check("single_pend0", int'(pend_a), 0);
    repeat (9) tick();
    e.cyc = cyc + 1;
    e.to  = 0;
    q_a.push_back(e);
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    tick();
    check_idle_a("single_end");

    // Burst of 4: counter saturates at 3, one drop, sticky overflow
    trig_a = 1'b1;
    repeat (4) tick();
    trig_a = 1'b0;
    check("burst_pend_sat", int'(pend_a), 3);
    check("burst_overflow", int'(ovf_a), 1);
    tick();
    check("burst_overflow_sticky", int'(ovf_a), 1);
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    check("burst_overflow_cleared", int'(ovf_a), 0);
    repeat (3) serve_a(0, 3);
    check_idle_a("burst_end");

    // Overflow event and clear on the same edge: overflow wins
    trig_a = 1'b1;
    repeat (3) tick();
    clr_a = 1'b1;
    tick();
    clr_a  = 1'b0;
    trig_a = 1'b0;
    check("ovf_vs_clear", int'(ovf_a), 1);
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    check("ovf_clear2", int'(ovf_a), 0);
    repeat (3) serve_a(1, 2);

    // Trigger coinciding with acceptance: count holds, one idle cycle between requests
    trig_a = 1'b1;
    tick();
    trig_a = 1'b0;
    wait_go(1'b0);
    trig_a = 1'b1;
    acc_a  = 1'b1;
    tick();
    trig_a = 1'b0;
    acc_a  = 1'b0;
    check("simul_pend", int'(pend_a), 1);
    check("simul_busy", int'(busy_a), 1);
    tick();
    e.cyc = cyc + 1;
    e.to  = 0;
    q_a.push_back(e);
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    tick();
    check("simul_idle_gap_go", int'(go_a), 0);
    check("simul_idle_gap_busy", int'(busy_a), 0);
    tick();
    check("simul_go_reassert", int'(go_a), 1);
    serve_a(0, 1);
    check_idle_a("simul_end");

    // Stray done_in / go_accept while idle
    done_a = 1'b1;
    acc_a  = 1'b1;
    tick();
    done_a = 1'b0;
    acc_a  = 1'b0;
    check_idle_a("stray");
    tick();
    check("stray_ack", int'(ack_a), 0);

    // Reset in BUSY with two pending: abort everything
    trig_a = 1'b1;
    repeat (3) tick();
    trig_a = 1'b0;
    wait_go(1'b0);
    acc_a = 1'b1;
    tick();
    acc_a = 1'b0;
    check("midrst_pend2", int'(pend_a), 2);
    check("midrst_busy", int'(busy_a), 1);
    rst = 1'b1;
    #1;
    check("midrst_async", int'({go_a, ack_a, busy_a, ovf_a, to_a, pend_a}), 0);
    tick();
    check("midrst_held", int'({go_a, ack_a, busy_a, ovf_a, to_a, pend_a}), 0);
    rst = 1'b0;
    repeat (10) tick();
    check_idle_a("midrst_after");

    // Watchdog expiry on instance b: ack + timeout 8 cycles after BUSY entry
    trig_b = 1'b1;
    tick();
    trig_b = 1'b0;
    wait_go(1'b1);
    acc_b = 1'b1;
    tick();
    acc_b = 1'b0;
    e.cyc = cyc + 8;
    e.to  = 1;
    q_b.push_back(e);
    repeat (7) tick();
    check("wd_still_busy", int'(busy_b), 1);
    repeat (4) tick();
    check("wd_back_idle", int'(busy_b), 0);

    // done_in on the expiry edge: ack only
    trig_b = 1'b1;
    tick();
    trig_b = 1'b0;
    wait_go(1'b1);
    acc_b = 1'b1;
    tick();
    acc_b = 1'b0;
    repeat (7) tick();
    e.cyc = cyc + 1;
    e.to  = 0;
    q_b.push_back(e);
    done_b = 1'b1;
    tick();
    done_b = 1'b0;
    repeat (4) tick();
    check("wd_end_busy", int'(busy_b), 0);

    repeat (3) tick();
    check("sb_a_drained", q_a.size(), 0);
    check("sb_b_drained", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
